// File: rtl/fejkon_fc_capture.sv
// fejkon_fc_capture
//   Debug tap on the 256-bit Avalon-ST FC packet path. Traffic passes through
//   combinationally and unchanged. When armed, whole packets are copied into
//   an on-chip beat buffer that host software drains over the CSR interface.
//
// Parameters
//   DEPTH  capture buffer depth in beats (power of two, 2..256)
//
// Ports
//   clk, reset                clock, asynchronous active-high reset
//   st_in_*                   Avalon-ST sink (from FC MAC receive)
//   st_out_*                  Avalon-ST source (to switch logic)
//   csr_address/write/read    32-bit CSR slave, word addressed
//   csr_writedata/readdata    readdata registered, valid one cycle after read
//
// CSR map
//   0x00 RW  remaining packets to capture (0xFFFFFFFF = unlimited)
//   0x01 RW  read: [31:16] level, [1] overflow, [0] busy; write bit1=1 clears overflow
//   0x02 RO  head metadata: [31] valid, [9:8] channel, [7] sop, [6] eop, [4:0] empty
//   0x03 WO  any write pops the head entry
//   0x10..0x17 RO head data word k = data[32k+31:32k]
module fejkon_fc_capture #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   st_in_channel,
  input  logic [255:0] st_in_data,
  input  logic         st_in_startofpacket,
  input  logic         st_in_endofpacket,
  input  logic [4:0]   st_in_empty,
  input  logic         st_in_valid,
  output logic         st_in_ready,
  output logic [1:0]   st_out_channel,
  output logic [255:0] st_out_data,
  output logic         st_out_startofpacket,
  output logic         st_out_endofpacket,
  output logic [4:0]   st_out_empty,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  input  logic [7:0]   csr_address,
  input  logic         csr_write,
  input  logic         csr_read,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 265;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [31:0]   REM_INFINITE = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE
  } state_t;

  state_t         state;
  logic [31:0]    remaining;
  logic [31:0]    rem_next;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic           overflow;

  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  entry;
  logic [EW-1:0]  head;

  logic           accepted;
  logic           sop_start;
  logic           store;
  logic           full;
  logic           empty_buf;
  logic           push;
  logic           pop;
  logic           rem_wr;
  logic           ovf_clr;
  logic [31:0]    rd_mux;

  // ---------------------------------------------------------------------------
  // Pass-through: capture never stalls the stream
  // ---------------------------------------------------------------------------
  assign st_out_channel       = st_in_channel;
  assign st_out_data          = st_in_data;
  assign st_out_startofpacket = st_in_startofpacket;
  assign st_out_endofpacket   = st_in_endofpacket;
  assign st_out_empty         = st_in_empty;
  assign st_out_valid         = st_in_valid;
  assign st_in_ready          = st_out_ready;

  // ---------------------------------------------------------------------------
  // Capture qualification
  // ---------------------------------------------------------------------------
  assign accepted  = st_in_valid & st_out_ready;
  // Only an SOP can open a capture, so a packet already in flight when the
  // tap is armed is skipped entirely rather than stored as a headless tail.
  assign sop_start = (state == S_ARMED) & accepted & st_in_startofpacket;
  assign store     = sop_start | ((state == S_CAPTURE) & accepted);

  assign full      = (level == FULL_LEVEL);
  assign empty_buf = (level == '0);
  assign push      = store & ~full;
  assign pop       = csr_write & (csr_address == 8'h03) & ~empty_buf;
  assign rem_wr    = csr_write & (csr_address == 8'h00);
  assign ovf_clr   = csr_write & (csr_address == 8'h01) & csr_writedata[1];

  assign entry = {st_in_channel, st_in_startofpacket, st_in_endofpacket,
                  st_in_empty, st_in_data};
  assign head  = mem[rd_ptr];

  // Host write wins over the SOP decrement in the same cycle.
  always_comb begin
    rem_next = remaining;
    if (rem_wr) begin
      rem_next = csr_writedata;
    end else if (sop_start && (remaining != REM_INFINITE)) begin
      rem_next = remaining - 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM and packet budget
  // ---------------------------------------------------------------------------
  // Outside CAPTURE the IDLE/ARMED choice simply follows the next budget, so
  // a host write of 0 disarms and a write of non-zero arms the tap. Inside
  // CAPTURE the packet is always finished before the budget is consulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      remaining <= rem_next;
      case (state)
        S_CAPTURE: begin
          if (accepted && st_in_endofpacket) begin
            state <= (rem_next != '0) ? S_ARMED : S_IDLE;
          end
        end
        default: begin
          if (sop_start && !st_in_endofpacket) begin
            state <= S_CAPTURE;
          end else begin
            state <= (rem_next != '0) ? S_ARMED : S_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Beat buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A beat that finds the buffer full is lost even if a pop frees a slot in
  // the same cycle; a same-cycle clear cannot hide that loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (store && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '1;
    if (csr_address == 8'h00) begin
      rd_mux = remaining;
    end else if (csr_address == 8'h01) begin
      rd_mux = {{(16-LW){1'b0}}, level, 14'd0, overflow, (state != S_IDLE)};
    end else if (csr_address == 8'h02) begin
      rd_mux = '0;
      if (!empty_buf) begin
        rd_mux = {1'b1, 21'd0, head[264:263], head[262], head[261], 1'b0,
                  head[260:256]};
      end
    end else if (csr_address[7:3] == 5'b00010) begin
      rd_mux = '0;
      if (!empty_buf) begin
        rd_mux = head[{csr_address[2:0], 5'b00000} +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_fejkon_fc_capture.sv
module tb_fejkon_fc_capture;

  localparam int unsigned DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   st_in_channel = '0;
  logic [255:0] st_in_data = '0;
  logic         st_in_startofpacket = 1'b0;
  logic         st_in_endofpacket = 1'b0;
  logic [4:0]   st_in_empty = '0;
  logic         st_in_valid = 1'b0;
  logic         st_in_ready;
  logic [1:0]   st_out_channel;
  logic [255:0] st_out_data;
  logic         st_out_startofpacket;
  logic         st_out_endofpacket;
  logic [4:0]   st_out_empty;
  logic         st_out_valid;
  logic         st_out_ready = 1'b1;
  logic [7:0]   csr_address = '0;
  logic         csr_write = 1'b0;
  logic         csr_read = 1'b0;
  logic [31:0]  csr_writedata = '0;
  logic [31:0]  csr_readdata;

  int n_cmp = 0;
  int n_bad = 0;

  fejkon_fc_capture #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .st_in_channel        (st_in_channel),
    .st_in_data           (st_in_data),
    .st_in_startofpacket  (st_in_startofpacket),
    .st_in_endofpacket    (st_in_endofpacket),
    .st_in_empty          (st_in_empty),
    .st_in_valid          (st_in_valid),
    .st_in_ready          (st_in_ready),
    .st_out_channel       (st_out_channel),
    .st_out_data          (st_out_data),
    .st_out_startofpacket (st_out_startofpacket),
    .st_out_endofpacket   (st_out_endofpacket),
    .st_out_empty         (st_out_empty),
    .st_out_valid         (st_out_valid),
    .st_out_ready         (st_out_ready),
    .csr_address          (csr_address),
    .csr_write            (csr_write),
    .csr_read             (csr_read),
    .csr_writedata        (csr_writedata),
    .csr_readdata         (csr_readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [271:0] act,
                       input logic [271:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: captured beats held as a queue of whole entries
  // ---------------------------------------------------------------------------
  logic [264:0] q[$];
  logic [31:0]  m_rem = '0;
  bit           m_in_pkt = 1'b0;
  bit           m_ovf = 1'b0;
  logic [31:0]  exp_rd = '0;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [264:0] h;
    int ai;
    ai = int'(a);
    h = (q.size() != 0) ? q[0] : '0;
    if (ai == 0) return m_rem;
    if (ai == 1) return {16'(q.size()), 14'd0, m_ovf, (m_in_pkt || m_rem != 0)};
    if (ai == 2) begin
      if (q.size() == 0) return '0;
      return {1'b1, 21'd0, h[264:263], h[262], h[261], 1'b0, h[260:256]};
    end
    if (ai >= 16 && ai <= 23) return h[32*(ai-16) +: 32];
    return 32'hFFFF_FFFF;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit take, start, was_full, do_pop;
    if (reset) begin
      q.delete();
      m_rem = '0;
      m_in_pkt = 1'b0;
      m_ovf = 1'b0;
      exp_rd = '0;
    end else begin
      if (csr_read) exp_rd = model_read(csr_address);
      take = 1'b0;
      start = 1'b0;
      if (st_in_valid && st_out_ready) begin
        if (m_in_pkt) take = 1'b1;
        else if (st_in_startofpacket && m_rem != 0) begin
          take = 1'b1;
          start = 1'b1;
        end
      end
      was_full = (q.size() == DEPTH);
      do_pop = csr_write && csr_address == 8'h03 && q.size() != 0;
      if (csr_write && csr_address == 8'h01 && csr_writedata[1]) m_ovf = 1'b0;
      if (do_pop) void'(q.pop_front());
      if (take) begin
        if (was_full) m_ovf = 1'b1;
        else q.push_back({st_in_channel, st_in_startofpacket, st_in_endofpacket,
                          st_in_empty, st_in_data});
        m_in_pkt = !st_in_endofpacket;
      end
      if (csr_write && csr_address == 8'h00) m_rem = csr_writedata;
      else if (start && m_rem != 32'hFFFF_FFFF) m_rem = m_rem - 1;
    end
  end

  // Continuous comparison, away from the active edge
  always @(negedge clk) begin
    check("passthru",
          {st_out_channel, st_out_data, st_out_startofpacket,
           st_out_endofpacket, st_out_empty, st_out_valid},
          {st_in_channel, st_in_data, st_in_startofpacket,
           st_in_endofpacket, st_in_empty, st_in_valid});
    check("ready", st_in_ready, st_out_ready);
    check("readdata", csr_readdata, exp_rd);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive 1 time unit after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input int p, input int b);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = {8'hC0, 8'(p), 8'(b), 8'(k)};
    return d;
  endfunction

  task automatic set_beat(input logic [1:0] ch, input bit sop, input bit eop,
                          input logic [4:0] emp, input int p, input int b);
    st_in_valid = 1'b1;
    st_in_channel = ch;
    st_in_startofpacket = sop;
    st_in_endofpacket = eop;
    st_in_empty = emp;
    st_in_data = mk(p, b);
  endtask

  task automatic beat(input logic [1:0] ch, input bit sop, input bit eop,
                      input logic [4:0] emp, input int p, input int b);
    set_beat(ch, sop, eop, emp, p, b);
    cyc();
  endtask

  task automatic idle();
    st_in_valid = 1'b0;
    st_in_startofpacket = 1'b0;
    st_in_endofpacket = 1'b0;
    cyc();
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    csr_address = a;
    csr_writedata = d;
    csr_write = 1'b1;
    cyc();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read = 1'b1;
    cyc();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] r;

    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    check("rst_readdata", csr_readdata, 32'h0);
    csr_rd(8'h01, r); check("rst_status", r, 32'h0000_0000);
    csr_rd(8'h00, r); check("rst_remaining", r, 32'h0000_0000);

    // Pass-through with ready gaps while idle
    for (int i = 0; i < 40; i++) begin
      st_out_ready = ($urandom_range(0, 4) != 0);
      st_in_valid = $urandom_range(0, 1);
      st_in_channel = 2'($urandom);
      st_in_startofpacket = $urandom_range(0, 1);
      st_in_endofpacket = $urandom_range(0, 1);
      st_in_empty = 5'($urandom);
      for (int k = 0; k < 8; k++) st_in_data[32*k +: 32] = $urandom;
      cyc();
    end
    st_out_ready = 1'b1;
    idle();
    csr_rd(8'h01, r); check("pt_level", r, 32'h0000_0000);

    // Budget of two packets; the third is passed but not stored
    csr_wr(8'h00, 32'd2);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 3; b++) beat(2'd1, b == 0, b == 2, (b == 2) ? 5'd4 : 5'd0, p, b);
      idle();
    end
    csr_rd(8'h01, r); check("cap2_status", r, 32'h0006_0000);
    csr_rd(8'h00, r); check("cap2_remaining", r, 32'h0000_0000);
    csr_rd(8'h02, r); check("cap2_head_meta", r, 32'h8000_0180);
    csr_rd(8'h10, r); check("cap2_word0", r, 32'hC000_0000);
    for (int k = 0; k < 8; k++) csr_rd(8'(16 + k), r);
    csr_rd(8'h13, r); check("cap2_word3", r, 32'hC000_0003);
    csr_wr(8'h03, 32'h0);
    csr_wr(8'h03, 32'h0);
    csr_rd(8'h02, r); check("cap2_eop_meta", r, 32'h8000_0144);
    for (int i = 0; i < 4; i++) begin
      csr_wr(8'h03, 32'h0);
      csr_rd(8'h02, r);
      for (int k = 0; k < 8; k++) csr_rd(8'(16 + k), r);
    end
    csr_rd(8'h02, r); check("cap2_drained_meta", r, 32'h0000_0000);
    csr_rd(8'h14, r); check("cap2_drained_word", r, 32'h0000_0000);

    // Arm while a packet is in flight: its tail must be skipped
    beat(2'd2, 1'b1, 1'b0, 5'd0, 5, 0);
    beat(2'd2, 1'b0, 1'b0, 5'd0, 5, 1);
    idle();
    csr_wr(8'h00, 32'd1);
    beat(2'd2, 1'b0, 1'b0, 5'd0, 5, 2);
    beat(2'd2, 1'b0, 1'b1, 5'd3, 5, 3);
    idle();
    for (int b = 0; b < 3; b++) beat(2'd2, b == 0, b == 2, 5'd0, 6, b);
    idle();
    csr_rd(8'h01, r); check("mid_status", r, 32'h0003_0000);
    csr_rd(8'h02, r); check("mid_head_meta", r, 32'h8000_0280);
    csr_rd(8'h10, r); check("mid_word0", r, 32'hC006_0000);
    repeat (3) csr_wr(8'h03, 32'h0);

    // Unlimited budget, 20-beat packet into a 16-deep buffer
    csr_wr(8'h00, 32'hFFFF_FFFF);
    for (int b = 0; b < 20; b++) beat(2'd0, b == 0, b == 19, 5'd0, 7, b);
    idle();
    csr_rd(8'h01, r); check("ovf_status", r, 32'h0010_0003);
    csr_rd(8'h00, r); check("ovf_remaining", r, 32'hFFFF_FFFF);
    csr_wr(8'h01, 32'h2);
    csr_rd(8'h01, r); check("ovf_cleared", r, 32'h0010_0001);
    csr_wr(8'h00, 32'h0);
    csr_rd(8'h01, r); check("disarmed", r, 32'h0010_0000);
    repeat (11) csr_wr(8'h03, 32'h0);
    csr_rd(8'h01, r); check("level5", r, 32'h0005_0000);

    // Push and pop in the same cycle
    csr_wr(8'h00, 32'd1);
    set_beat(2'd3, 1'b1, 1'b1, 5'd9, 8, 0);
    csr_address = 8'h03;
    csr_write = 1'b1;
    cyc();
    csr_write = 1'b0;
    idle();
    csr_rd(8'h01, r); check("pushpop_level", r, 32'h0005_0000);
    csr_rd(8'h02, r); check("pushpop_meta", r, 32'h8000_0000);
    csr_rd(8'h10, r); check("pushpop_word0", r, 32'hC007_0C00);
    repeat (4) csr_wr(8'h03, 32'h0);
    csr_rd(8'h02, r); check("single_beat_meta", r, 32'h8000_03C9);
    csr_wr(8'h03, 32'h0);
    csr_wr(8'h03, 32'h0);
    csr_rd(8'h01, r); check("underflow", r, 32'h0000_0000);

    // Reset in the middle of a capture
    csr_wr(8'h00, 32'd1);
    for (int b = 0; b < 4; b++) beat(2'd3, b == 0, 1'b0, 5'd0, 9, b);
    st_in_valid = 1'b0;
    csr_rd(8'h01, r); check("precut_status", r, 32'h0004_0001);
    reset = 1'b1;
    set_beat(2'd3, 1'b0, 1'b0, 5'd0, 9, 4);
    cyc();
    check("rst_mid_readdata", csr_readdata, 32'h0);
    reset = 1'b0;
    idle();
    csr_rd(8'h01, r); check("rst_mid_status", r, 32'h0000_0000);
    csr_rd(8'h05, r); check("bad_addr", r, 32'hFFFF_FFFF);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
